hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RV32 core. Drives PC/IF-ID enables, IF-ID and DEC (ID/EX) flush,
//  and stage holds. Detects load-use hazards, applies branch-taken flushes, freezes the pipe on data-memory wait
//  (with watchdog), and holds the pipe flushed for a fixed warm-up after reset. Sits beside the stage registers; outputs feed them directly.

---
 rtl/pipe_ctrl_pkg.sv | 8 +
 rtl/hazard_ctrl_perf.sv | 23 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding and register constants.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, FAULT} hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_perf.sv
// Saturating performance counters for stall cycles and applied branch flushes.
module hazard_ctrl_perf (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        stall_evt,
    input  logic        flush_evt,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_evt && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (flush_evt && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: reset warm-up, load-use stall, branch flush, memory wait with watchdog.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RESET_HOLD  = 4,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [4:0]  dec_rd,
    input  logic        dec_Rmem,
    input  logic [4:0]  id_addr1,
    input  logic [4:0]  id_addr2,
    input  logic        id_use1,
    input  logic        id_use2,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        dec_flush,
    output logic        pipe_hold,
    output logic        fault,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [31:0] HOLD_LOAD = 32'(RESET_HOLD - 1);
    localparam logic [31:0] WAIT_LOAD = 32'(MEM_TIMEOUT - 2);

    hz_state_t   state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        load_use;
    logic        run_eval;

    assign load_use = dec_Rmem && (dec_rd != REG_ZERO) &&
                      ((id_use1 && (id_addr1 == dec_rd)) || (id_use2 && (id_addr2 == dec_rd)));

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= INIT;
            cnt   <= HOLD_LOAD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter is shared: warm-up length in INIT, remaining wait budget in MEM_WAIT.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        dec_flush  = 1'b0;
        pipe_hold  = 1'b0;
        fault      = 1'b0;
        run_eval   = 1'b0;

        case (state)
            INIT: begin
                ifid_flush = 1'b1;
                dec_flush  = 1'b1;
                if (cnt == 32'd0)
                    state_nxt = RUN;
                else
                    cnt_nxt = cnt - 32'd1;
            end
            RUN: begin
                if (mem_req && !mem_ready) begin
                    pipe_hold = 1'b1;
                    cnt_nxt   = WAIT_LOAD;
                    state_nxt = MEM_WAIT;
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    pipe_hold = 1'b1;
                    if (cnt == 32'd0)
                        state_nxt = FAULT;
                    else
                        cnt_nxt = cnt - 32'd1;
                end else begin
                    run_eval  = 1'b1;
                    state_nxt = RUN;
                end
            end
            FAULT: begin
                fault     = 1'b1;
                pipe_hold = 1'b1;
                dec_flush = 1'b1;
            end
            default: state_nxt = INIT;
        endcase

        // A taken branch squashes both younger instructions, so a pending load-use is moot.
        if (run_eval) begin
            if (branch_taken) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                dec_flush  = 1'b1;
            end else if (load_use) begin
                dec_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_evt, flush_evt;

    // pc_en with ifid_flush only occurs for an applied branch; INIT never raises pc_en.
    assign stall_evt = !pc_en && ((state == RUN) || (state == MEM_WAIT));
    assign flush_evt = pc_en && ifid_flush;

    hazard_ctrl_perf u_perf (
        .Clock        (Clock),
        .nReset       (nReset),
        .stall_evt    (stall_evt),
        .flush_evt    (flush_evt),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (RESET_HOLD=4, MEM_TIMEOUT=8).
module tb_hazard_ctrl;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic [4:0]  dec_rd, id_addr1, id_addr2;
    logic        dec_Rmem, id_use1, id_use2, branch_taken, mem_req, mem_ready;
    logic        pc_en, ifid_en, ifid_flush, dec_flush, pipe_hold, fault;
    logic [31:0] stall_cycles, flush_count;
    logic [5:0]  outs;

    int passed = 0;
    int total  = 0;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: {pc_en, ifid_en, ifid_flush, dec_flush, pipe_hold, fault}
    localparam logic [5:0] O_INIT  = 6'b001100;
    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_LU    = 6'b000100;
    localparam logic [5:0] O_BR    = 6'b111100;
    localparam logic [5:0] O_HOLD  = 6'b000010;
    localparam logic [5:0] O_FAULT = 6'b000111;

    assign outs = {pc_en, ifid_en, ifid_flush, dec_flush, pipe_hold, fault};

    hazard_ctrl #(.RESET_HOLD(4), .MEM_TIMEOUT(8)) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .dec_rd       (dec_rd),
        .dec_Rmem     (dec_Rmem),
        .id_addr1     (id_addr1),
        .id_addr2     (id_addr2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .dec_flush    (dec_flush),
        .pipe_hold    (pipe_hold),
        .fault        (fault),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 Clock = ~Clock;

    task automatic clear_inputs();
        dec_rd = 5'd0; id_addr1 = 5'd0; id_addr2 = 5'd0;
        dec_Rmem = 1'b0; id_use1 = 1'b0; id_use2 = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Leaves the DUT in RUN, aligned to a falling edge.
    task automatic do_reset();
        nReset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge Clock);
        #1;
        total++;
        if (outs !== O_INIT) $display("[TB] FAIL reset_outs: got %b expected %b", outs, O_INIT);
        else passed++;
        total++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0)
            $display("[TB] FAIL reset_perf: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        else passed++;
        @(negedge Clock);
        nReset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (outs !== O_INIT) $display("[TB] FAIL init_cycle%0d: got %b expected %b", i, outs, O_INIT);
            else passed++;
            @(negedge Clock);
        end
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL run_after_hold: got %b expected %b", outs, O_RUN);
        else passed++;
    endtask

    task automatic test_load_use();
        @(negedge Clock);
        dec_Rmem = 1'b1; dec_rd = 5'd5; id_addr1 = 5'd5; id_use1 = 1'b1;
        #1;
        total++;
        if (outs !== O_LU) $display("[TB] FAIL lu_rs1: got %b expected %b", outs, O_LU);
        else passed++;
        @(negedge Clock);
        dec_Rmem = 1'b0;
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL lu_cleared: got %b expected %b", outs, O_RUN);
        else passed++;
        @(negedge Clock);
        dec_Rmem = 1'b1; dec_rd = 5'd0; id_addr1 = 5'd0;
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL lu_x0: got %b expected %b", outs, O_RUN);
        else passed++;
        @(negedge Clock);
        dec_rd = 5'd5; id_addr1 = 5'd5; id_use1 = 1'b0;
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL lu_nouse: got %b expected %b", outs, O_RUN);
        else passed++;
        @(negedge Clock);
        id_use2 = 1'b1; id_addr2 = 5'd5;
        #1;
        total++;
        if (outs !== O_LU) $display("[TB] FAIL lu_rs2: got %b expected %b", outs, O_LU);
        else passed++;
        @(negedge Clock);
        id_addr2 = 5'd6;
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL lu_rs2_diff: got %b expected %b", outs, O_RUN);
        else passed++;
        @(negedge Clock);
        clear_inputs();
        mem_ready = 1'b1;
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL ready_no_req: got %b expected %b", outs, O_RUN);
        else passed++;
        @(negedge Clock);
        mem_ready = 1'b0;
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL ready_no_req_state: got %b expected %b", outs, O_RUN);
        else passed++;
    endtask

    task automatic test_branch();
        do_reset();
        dec_Rmem = 1'b1; dec_rd = 5'd5; id_addr1 = 5'd5; id_use1 = 1'b1; branch_taken = 1'b1;
        #1;
        total++;
        if (outs !== O_BR) $display("[TB] FAIL branch_over_lu: got %b expected %b", outs, O_BR);
        else passed++;
        @(negedge Clock);
        clear_inputs();
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL branch_after: got %b expected %b", outs, O_RUN);
        else passed++;
        total++;
        if (flush_count !== (PERF ? 32'd1 : 32'd0) || stall_cycles !== 32'd0)
            $display("[TB] FAIL branch_perf: got flush %0d stall %0d expected flush %0d stall 0",
                     flush_count, stall_cycles, PERF ? 1 : 0);
        else passed++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (outs !== O_HOLD) $display("[TB] FAIL mw_hold%0d: got %b expected %b", i, outs, O_HOLD);
            else passed++;
            @(negedge Clock);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL mw_release: got %b expected %b", outs, O_RUN);
        else passed++;
        @(negedge Clock);
        clear_inputs();
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL mw_after: got %b expected %b", outs, O_RUN);
        else passed++;
        total++;
        if (stall_cycles !== (PERF ? 32'd3 : 32'd0))
            $display("[TB] FAIL mw_stall_perf: got %0d expected %0d", stall_cycles, PERF ? 3 : 0);
        else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++;
            if (outs !== O_HOLD) $display("[TB] FAIL to_hold%0d: got %b expected %b", i, outs, O_HOLD);
            else passed++;
            @(negedge Clock);
        end
        #1;
        total++;
        if (outs !== O_FAULT) $display("[TB] FAIL to_fault: got %b expected %b", outs, O_FAULT);
        else passed++;
        mem_req = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge Clock);
        #1;
        total++;
        if (outs !== O_FAULT) $display("[TB] FAIL to_sticky: got %b expected %b", outs, O_FAULT);
        else passed++;
        total++;
        if (stall_cycles !== (PERF ? 32'd8 : 32'd0))
            $display("[TB] FAIL to_stall_perf: got %0d expected %0d", stall_cycles, PERF ? 8 : 0);
        else passed++;
        nReset = 1'b0;
        #1;
        total++;
        if (outs !== O_INIT) $display("[TB] FAIL to_reset: got %b expected %b", outs, O_INIT);
        else passed++;
        @(negedge Clock);
        clear_inputs();
        nReset = 1'b1;
        #1;
        total++;
        if (outs !== O_INIT) $display("[TB] FAIL to_reinit: got %b expected %b", outs, O_INIT);
        else passed++;
    endtask

    task automatic test_mem_branch();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (outs !== O_HOLD) $display("[TB] FAIL mb_hold%0d: got %b expected %b", i, outs, O_HOLD);
            else passed++;
            @(negedge Clock);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (outs !== O_BR) $display("[TB] FAIL mb_release: got %b expected %b", outs, O_BR);
        else passed++;
        @(negedge Clock);
        clear_inputs();
        #1;
        total++;
        if (flush_count !== (PERF ? 32'd1 : 32'd0))
            $display("[TB] FAIL mb_flush_perf: got %0d expected %0d", flush_count, PERF ? 1 : 0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        total++;
        if (outs !== O_HOLD) $display("[TB] FAIL bb_hold: got %b expected %b", outs, O_HOLD);
        else passed++;
        @(negedge Clock);
        mem_ready = 1'b1;
        dec_Rmem = 1'b1; dec_rd = 5'd9; id_addr2 = 5'd9; id_use2 = 1'b1;
        #1;
        total++;
        if (outs !== O_LU) $display("[TB] FAIL bb_release_lu: got %b expected %b", outs, O_LU);
        else passed++;
        @(negedge Clock);
        clear_inputs();
        #1;
        total++;
        if (outs !== O_RUN) $display("[TB] FAIL bb_run: got %b expected %b", outs, O_RUN);
        else passed++;
        total++;
        if (stall_cycles !== (PERF ? 32'd2 : 32'd0))
            $display("[TB] FAIL bb_stall_perf: got %0d expected %0d", stall_cycles, PERF ? 2 : 0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_mem_branch();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
